// File: rtl/fetch_issue_pipe.sv
// Front-end pipeline controller: fetch PC, fetch->issue and issue->execute registers
// under stall/flush/redirect control. Optional stall-cycle counter: define STALL_CNT_EN.
module fetch_issue_pipe #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_fetch_i,
    input  logic        stall_iss_i,
    input  logic        flush_ex_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] instr_rdata_i,
    output logic [31:0] pc_fetch_o,
    output logic [31:0] instr_iss_o,
    output logic [31:0] pc_iss_o,
    output logic        valid_iss_o,
    output logic [31:0] instr_ex_o,
    output logic [31:0] pc_ex_o,
    output logic        valid_ex_o,
    output logic [4:0]  rs_ex_o,
    output logic [4:0]  rt_ex_o,
    output logic [4:0]  rd_ex_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] r_pc;
    logic [31:0] r_instr_iss;
    logic [31:0] r_pc_iss;
    logic        r_valid_iss;
    logic [31:0] r_instr_ex;
    logic [31:0] r_pc_ex;
    logic        r_valid_ex;
    logic [4:0]  r_rs_ex;
    logic [4:0]  r_rt_ex;
    logic [4:0]  r_rd_ex;

    logic        w_stall_any;
    logic        w_hold_f;
    logic        w_bubble_ex;

    // An issue stall also freezes the PC so the fetched word is never lost.
    assign w_stall_any = stall_fetch_i | stall_iss_i;
    assign w_hold_f    = w_stall_any & ~branch_taken_i;
    assign w_bubble_ex = branch_taken_i | flush_ex_i | stall_iss_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (branch_taken_i) begin
            r_pc <= {branch_target_i[31:2], 2'b00};
        end else if (!w_hold_f) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_iss <= NOP_INSTR;
            r_pc_iss    <= 32'h0;
            r_valid_iss <= 1'b0;
        end else if (branch_taken_i) begin
            r_instr_iss <= NOP_INSTR;
            r_pc_iss    <= 32'h0;
            r_valid_iss <= 1'b0;
        end else if (!stall_iss_i) begin
            r_instr_iss <= instr_rdata_i;
            r_pc_iss    <= r_pc;
            r_valid_iss <= 1'b1;
        end
    end

    // A held issue stage always bubbles execute, so nothing is issued twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_ex <= NOP_INSTR;
            r_pc_ex    <= 32'h0;
            r_valid_ex <= 1'b0;
            r_rs_ex    <= 5'd0;
            r_rt_ex    <= 5'd0;
            r_rd_ex    <= 5'd0;
        end else if (w_bubble_ex) begin
            r_instr_ex <= NOP_INSTR;
            r_pc_ex    <= 32'h0;
            r_valid_ex <= 1'b0;
            r_rs_ex    <= 5'd0;
            r_rt_ex    <= 5'd0;
            r_rd_ex    <= 5'd0;
        end else begin
            r_instr_ex <= r_instr_iss;
            r_pc_ex    <= r_pc_iss;
            r_valid_ex <= r_valid_iss;
            r_rs_ex    <= r_instr_iss[25:21];
            r_rt_ex    <= r_instr_iss[20:16];
            r_rd_ex    <= r_instr_iss[15:11];
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'h0;
        end else if (w_hold_f && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

    assign pc_fetch_o  = r_pc;
    assign instr_iss_o = r_instr_iss;
    assign pc_iss_o    = r_pc_iss;
    assign valid_iss_o = r_valid_iss;
    assign instr_ex_o  = r_instr_ex;
    assign pc_ex_o     = r_pc_ex;
    assign valid_ex_o  = r_valid_ex;
    assign rs_ex_o     = r_rs_ex;
    assign rt_ex_o     = r_rt_ex;
    assign rd_ex_o     = r_rd_ex;

endmodule

// File: tb/tb_fetch_issue_pipe.sv
// Scoreboard bench for fetch_issue_pipe: directed hazard sequences, execute-stage
// scoreboard, plus a second instance reset near the top of the address space.
module tb_fetch_issue_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_t;

    logic        clk;
    logic        rst_n;
    logic        stall_fetch_i;
    logic        stall_iss_i;
    logic        flush_ex_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] instr_rdata_i;
    logic [31:0] pc_fetch_o;
    logic [31:0] instr_iss_o;
    logic [31:0] pc_iss_o;
    logic        valid_iss_o;
    logic [31:0] instr_ex_o;
    logic [31:0] pc_ex_o;
    logic        valid_ex_o;
    logic [4:0]  rs_ex_o;
    logic [4:0]  rt_ex_o;
    logic [4:0]  rd_ex_o;
    logic [31:0] stall_cnt_o;

    logic [31:0] b_pc_fetch;
    logic [31:0] b_instr_iss;
    logic [31:0] b_pc_iss;
    logic        b_valid_iss;
    logic [31:0] b_instr_ex;
    logic [31:0] b_pc_ex;
    logic        b_valid_ex;
    logic [4:0]  b_rs;
    logic [4:0]  b_rt;
    logic [4:0]  b_rd;
    logic [31:0] b_cnt;

    int  total = 0;
    int  bad   = 0;
    logic mon_en;
    ex_t exp_q[$];

    fetch_issue_pipe #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .stall_fetch_i(stall_fetch_i), .stall_iss_i(stall_iss_i),
        .flush_ex_i(flush_ex_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .instr_rdata_i(instr_rdata_i),
        .pc_fetch_o(pc_fetch_o), .instr_iss_o(instr_iss_o), .pc_iss_o(pc_iss_o),
        .valid_iss_o(valid_iss_o), .instr_ex_o(instr_ex_o), .pc_ex_o(pc_ex_o),
        .valid_ex_o(valid_ex_o), .rs_ex_o(rs_ex_o), .rt_ex_o(rt_ex_o),
        .rd_ex_o(rd_ex_o), .stall_cnt_o(stall_cnt_o)
    );

    fetch_issue_pipe #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .stall_fetch_i(1'b0), .stall_iss_i(1'b0),
        .flush_ex_i(1'b0), .branch_taken_i(1'b0),
        .branch_target_i(32'h0), .instr_rdata_i(b_pc_fetch),
        .pc_fetch_o(b_pc_fetch), .instr_iss_o(b_instr_iss), .pc_iss_o(b_pc_iss),
        .valid_iss_o(b_valid_iss), .instr_ex_o(b_instr_ex), .pc_ex_o(b_pc_ex),
        .valid_ex_o(b_valid_ex), .rs_ex_o(b_rs), .rt_ex_o(b_rt),
        .rd_ex_o(b_rd), .stall_cnt_o(b_cnt)
    );

    // Memory returns the address as data, except one R-type word at 0x14.
    assign instr_rdata_i = (pc_fetch_o == 32'h14) ? 32'h012A_4020 : pc_fetch_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ex_t e;
        e.pc = pc; e.instr = instr; e.rs = rs; e.rt = rt; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pc_fetch"}, pc_fetch_o, 32'h0);
        chk({tag, " valid_iss"}, {31'h0, valid_iss_o}, 32'h0);
        chk({tag, " valid_ex"}, {31'h0, valid_ex_o}, 32'h0);
        chk({tag, " instr_iss"}, instr_iss_o, 32'h0);
        chk({tag, " instr_ex"}, instr_ex_o, 32'h0);
        chk({tag, " pc_iss"}, pc_iss_o, 32'h0);
        chk({tag, " pc_ex"}, pc_ex_o, 32'h0);
        chk({tag, " rs_rt_rd"}, {17'h0, rs_ex_o, rt_ex_o, rd_ex_o}, 32'h0);
        chk({tag, " stall_cnt"}, stall_cnt_o, 32'h0);
    endtask

    // Execute-stage monitor: every valid instruction must match the next expected entry.
    always @(negedge clk) begin
        if (mon_en && rst_n && valid_ex_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ex_unexpected: got pc %h with no expected entry", pc_ex_o);
            end else begin
                ex_t e;
                e = exp_q.pop_front();
                chk("ex_pc", pc_ex_o, e.pc);
                chk("ex_instr", instr_ex_o, e.instr);
                chk("ex_fields", {17'h0, rs_ex_o, rt_ex_o, rd_ex_o}, {17'h0, e.rs, e.rt, e.rd});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        stall_fetch_i = 1'b0; stall_iss_i = 1'b0; flush_ex_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = 32'h0;
        mon_en = 1'b1;

        push(32'h000, 32'h000, 5'd0, 5'd0,  5'd0);
        push(32'h004, 32'h004, 5'd0, 5'd0,  5'd0);
        push(32'h008, 32'h008, 5'd0, 5'd0,  5'd0);
        push(32'h00C, 32'h00C, 5'd0, 5'd0,  5'd0);
        push(32'h010, 32'h010, 5'd0, 5'd0,  5'd0);
        push(32'h014, 32'h012A_4020, 5'd9, 5'd10, 5'd8);
        push(32'h100, 32'h100, 5'd0, 5'd0,  5'd0);
        push(32'h108, 32'h108, 5'd0, 5'd0,  5'd0);
        push(32'h10C, 32'h10C, 5'd0, 5'd0,  5'd0);
        push(32'h110, 32'h110, 5'd0, 5'd0,  5'd0);
        push(32'h114, 32'h114, 5'd0, 5'd0,  5'd0);
        push(32'h114, 32'h114, 5'd0, 5'd0,  5'd0);

        @(negedge clk); @(negedge clk);
        chk_reset_vals("rst");
        chk("wrap pc0", b_pc_fetch, 32'hFFFF_FFF8);
        rst_n = 1'b1;

        @(negedge clk);  // E1
        chk("e1 pc_fetch", pc_fetch_o, 32'h4);
        chk("e1 valid_iss", {31'h0, valid_iss_o}, 32'h1);
        chk("e1 pc_iss", pc_iss_o, 32'h0);
        chk("e1 valid_ex", {31'h0, valid_ex_o}, 32'h0);
        chk("wrap pc1", b_pc_fetch, 32'hFFFF_FFFC);
        @(negedge clk);  // E2
        chk("e2 pc_fetch", pc_fetch_o, 32'h8);
        chk("e2 valid_ex", {31'h0, valid_ex_o}, 32'h1);
        chk("wrap pc2", b_pc_fetch, 32'h0);
        @(negedge clk);  // E3
        chk("e3 pc_fetch", pc_fetch_o, 32'hC);
        chk("e3 pc_iss", pc_iss_o, 32'h8);
        stall_iss_i = 1'b1;
        @(negedge clk);  // E4: load-use stall
        chk("lu pc_hold", pc_fetch_o, 32'hC);
        chk("lu iss_hold", pc_iss_o, 32'h8);
        chk("lu ex_bubble", {31'h0, valid_ex_o}, 32'h0);
        chk("lu ex_fields", {17'h0, rs_ex_o, rt_ex_o, rd_ex_o}, 32'h0);
`ifdef STALL_CNT_EN
        chk("cnt after lu", stall_cnt_o, 32'd1);
`endif
        stall_iss_i = 1'b0;
        @(negedge clk);  // E5
        chk("e5 pc_fetch", pc_fetch_o, 32'h10);
        chk("e5 pc_iss", pc_iss_o, 32'hC);
        @(negedge clk); @(negedge clk); @(negedge clk);  // E6..E8
        branch_taken_i = 1'b1; branch_target_i = 32'h0000_0103; stall_iss_i = 1'b1;
        @(negedge clk);  // E9: branch wins over stall
        chk("br pc_fetch", pc_fetch_o, 32'h100);
        chk("br valid_iss", {31'h0, valid_iss_o}, 32'h0);
        chk("br instr_iss", instr_iss_o, 32'h0);
        chk("br valid_ex", {31'h0, valid_ex_o}, 32'h0);
`ifdef STALL_CNT_EN
        chk("cnt after br", stall_cnt_o, 32'd1);
`endif
        branch_taken_i = 1'b0; branch_target_i = 32'h0; stall_iss_i = 1'b0;
        @(negedge clk);  // E10
        chk("tgt pc_iss", pc_iss_o, 32'h100);
        chk("tgt instr_iss", instr_iss_o, 32'h100);
        chk("tgt valid_iss", {31'h0, valid_iss_o}, 32'h1);
        chk("tgt valid_ex", {31'h0, valid_ex_o}, 32'h0);
        @(negedge clk);  // E11
        flush_ex_i = 1'b1;
        @(negedge clk);  // E12: flush, issue advances
        chk("fl pc_iss", pc_iss_o, 32'h108);
        chk("fl valid_ex", {31'h0, valid_ex_o}, 32'h0);
        chk("fl pc_ex", pc_ex_o, 32'h0);
        flush_ex_i = 1'b0;
        @(negedge clk); @(negedge clk);  // E13, E14
        stall_fetch_i = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);  // E15..E17
        chk("sf pc_hold", pc_fetch_o, 32'h114);
`ifdef STALL_CNT_EN
        chk("cnt after sf", stall_cnt_o, 32'd4);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end

        // Stall counter phase
        mon_en = 1'b0;
        stall_fetch_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stall_fetch_i = 1'b1;
        repeat (5) @(negedge clk);
        branch_taken_i = 1'b1; branch_target_i = 32'h40;
        @(negedge clk);
        branch_taken_i = 1'b0; stall_fetch_i = 1'b0;
        @(negedge clk);
`ifdef STALL_CNT_EN
        chk("cnt five", stall_cnt_o, 32'd5);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        stall_fetch_i = 1'b1;
        repeat (3) @(negedge clk);
        stall_fetch_i = 1'b0;
        chk("cnt sat", stall_cnt_o, 32'hFFFF_FFFF);
`else
        chk("cnt off", stall_cnt_o, 32'h0);
`endif
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_issue_pipe.md
# fetch_issue_pipe

Front-end pipeline controller that acts on the hazard unit's requests. It owns the fetch PC, the fetch→issue register and the issue→execute register, and applies stall, flush and branch-redirect commands to them. It also drives the decoded rs/rt/rd fields of the instruction in execute, which the hazard unit compares against in-flight destination registers.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset (word aligned)
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0)

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_fetch_i  in  1  hold PC
- stall_iss_i  in  1  hold issue register
- flush_ex_i  in  1  load bubble into execute register
- branch_taken_i  in  1  redirect from execute, one-cycle pulse
- branch_target_i  in  32  redirect address
- instr_rdata_i  in  32  instruction memory read data for pc_fetch_o, combinational
- pc_fetch_o  out  32  instruction memory address
- instr_iss_o / pc_iss_o  out  32 / 32  issue-stage instruction and PC
- valid_iss_o  out  1  issue stage holds a real instruction
- instr_ex_o / pc_ex_o  out  32 / 32  execute-stage instruction and PC
- valid_ex_o  out  1  execute stage holds a real instruction
- rs_ex_o / rt_ex_o / rd_ex_o  out  5 each  instr_ex_o[25:21] / [20:16] / [15:11], registered
- stall_cnt_o  out  32  stall-cycle count (see Configuration)

## Operation
- Effective fetch hold: hold_f = (stall_fetch_i | stall_iss_i) & ~branch_taken_i. stall_iss_i alone also holds the PC, so a fetched instruction is never dropped.
- PC update, by priority:
  - branch_taken_i: pc ← {branch_target_i[31:2], 2'b00}.
  - hold_f: pc holds.
  - Otherwise: pc ← pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Issue register, by priority:
  - branch_taken_i: instr ← NOP_INSTR, valid ← 0.
  - stall_iss_i: hold all fields.
  - Otherwise: instr ← instr_rdata_i, pc_iss ← pc_fetch_o, valid ← 1.
- Execute register, by priority:
  - branch_taken_i, flush_ex_i or stall_iss_i: bubble. instr ← NOP_INSTR, valid ← 0, rs/rt/rd ← 0, pc_ex ← 0.
  - Otherwise: load from the issue register. rs/rt/rd are decoded from the incoming instruction. valid_ex ← valid_iss.
- stall_iss_i always bubbles execute, so an issue instruction is never duplicated into execute.
- No state machine beyond the three registers. Each stage is either valid or a bubble.

## Timing
- Reset (async assert, sync release on clk):
  - pc_fetch_o = RESET_PC.
  - valid_iss_o = valid_ex_o = 0.
  - instr_iss_o = instr_ex_o = NOP_INSTR.
  - pc_iss_o = pc_ex_o = 0.
  - rs/rt/rd_ex_o = 0.
  - stall_cnt_o = 0.
- Latency with no hazards: the instruction at address A is on pc_fetch_o in cycle t, in issue at t+1 and in execute at t+2.
- First valid issue is the first edge after reset release; first valid execute is the second.
- Branch sampled at edge t: pc_fetch_o = target at t+1, and the issue and execute stages are bubbles at t+1. Redirect penalty is 2 bubbles.
- Branch together with any stall or flush: the branch wins. Stalls asserted in that cycle are ignored.
- flush_ex_i without stalls: issue still advances (new fetch enters issue) and execute takes a bubble.
- Reset asserted mid-stall: all state returns to reset values immediately. Stall inputs have no effect while rst_n = 0.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- STALL_CNT_EN defined: stall_cnt_o increments by 1 on every clock where (stall_fetch_i | stall_iss_i) & ~branch_taken_i & rst_n.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by reset.
- STALL_CNT_EN undefined: no counter is built and stall_cnt_o is tied to 32'h0.

## Test plan
- Free-run: release reset with RESET_PC = 0 and memory returning instr = address. pc_fetch_o steps 0, 4, 8. Execute sees pc_ex_o = 0 with valid_ex_o = 1 on the 2nd edge. Instruction 32'h012A_4020 gives rs = 9, rt = 10, rd = 8.
- Load-use: pulse stall_iss_i = 1 for one cycle while issue holds pc 8. PC holds at 12, issue holds pc 8, and execute shows a bubble (valid 0, rs/rt/rd = 0). Next cycle pc 8 enters execute exactly once.
- Branch over stall: branch_taken_i = 1, target 32'h0000_0103, and stall_iss_i = 1 in the same cycle. pc_fetch_o = 32'h0000_0100 and both stages become bubbles. Issue receives the target instruction one cycle later.
- Wrap: RESET_PC = 32'hFFFF_FFF8 with no stalls. pc_fetch_o sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset mid-stall: hold stall_fetch_i = 1 for 3 cycles, then drop rst_n asynchronously between edges. Outputs show reset values before the next clk edge.
- STALL_CNT_EN: 5 stall cycles plus 1 stall cycle coincident with a branch gives stall_cnt_o = 5. Preloading the counter to FFFF_FFFE via force and adding 3 stalls gives FFFF_FFFF. With the macro undefined, stall_cnt_o stays 0.
